// File: rtl/uart_mux_pkg.sv
// ============================================================================
// Module      : uart_mux_pkg
// Description : Shared definitions for the tagged UART frame format.
//               Header byte = {sync nibble, channel number}, followed by a
//               length byte and that many payload bytes. These constants are
//               used by the decoder (demux) as well as by the encoder
//               direction toward the host.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_mux_pkg;

    // Required value of header bits [7:4]
    localparam logic [3:0] c_SYNC_NIBBLE = 4'hA;

    // Header field positions
    localparam int c_HDR_SYNC_MSB = 7;
    localparam int c_HDR_SYNC_LSB = 4;
    localparam int c_HDR_CH_MSB   = 3;
    localparam int c_HDR_CH_LSB   = 0;

    // Decoder state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LEN  = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_DROP = 2'd3;

    // Extract the sync field of a header byte
    function automatic logic [3:0] hdr_sync(input logic [7:0] i_byte);
        return i_byte[c_HDR_SYNC_MSB:c_HDR_SYNC_LSB];
    endfunction

    // Extract the channel field of a header byte
    function automatic logic [3:0] hdr_chan(input logic [7:0] i_byte);
        return i_byte[c_HDR_CH_MSB:c_HDR_CH_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_frame_timeout.sv
// ============================================================================
// Module      : uart_frame_timeout
// Description : Inter-byte idle counter with a terminal pulse.
//               Ports:
//                 clk      - system clock
//                 reset    - synchronous, active-high reset
//                 i_clear  - clear request (byte popped or decoder idle)
//                 o_expire - one-cycle pulse on the TIMEOUT_CYCLES-th
//                            consecutive cycle without a clear
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_timeout #(
    parameter int COUNTER_BITS   = 16,
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_expire
);

    // r_cnt holds the number of idle cycles already elapsed, so the
    // cycle that would bring it to TIMEOUT_CYCLES is the one that fires.
    localparam logic [COUNTER_BITS-1:0] c_LAST = COUNTER_BITS'(TIMEOUT_CYCLES - 1);

    logic [COUNTER_BITS-1:0] r_cnt;

    // A clear in the same cycle always wins over expiry.
    assign o_expire = !i_clear && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_frame_demux.sv
// ============================================================================
// Module      : uart_frame_demux
// Description : Decodes the tagged byte stream from the USB UART RX FIFO
//               (first-word-fall-through) and routes each frame payload to
//               one of UART_COUNT channel TX FIFOs.
//               Ports:
//                 clk, reset   - clock, synchronous active-high reset
//                 fifo_empty   - RX FIFO empty
//                 fifo_data    - RX FIFO head byte
//                 fifo_read    - RX FIFO pop strobe
//                 full         - per-channel TX FIFO full
//                 write        - per-channel TX write strobe (one-hot/zero)
//                 data         - shared TX write data
//                 frame_error  - one-cycle pulse per detected error
//                 error_count  - saturating error total
//                 busy         - high while a frame is being decoded
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_demux
    import uart_mux_pkg::*;
#(
    parameter int         DATA_BITS      = 8,
    parameter int         UART_COUNT     = 4,
    parameter int         COUNTER_BITS   = 16,
    parameter logic [3:0] SYNC_NIBBLE    = c_SYNC_NIBBLE,
    parameter int         TIMEOUT_CYCLES = 60000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_empty,
    input  logic [DATA_BITS-1:0]    fifo_data,
    output logic                    fifo_read,
    input  logic [UART_COUNT-1:0]   full,
    output logic [UART_COUNT-1:0]   write,
    output logic [DATA_BITS-1:0]    data,
    output logic                    frame_error,
    output logic [COUNTER_BITS-1:0] error_count,
    output logic                    busy
);

    localparam logic [4:0] c_UART_COUNT = 5'(UART_COUNT);

    logic [1:0]              r_state;
    logic [3:0]              r_channel;
    logic [DATA_BITS-1:0]    r_remaining;
    logic [COUNTER_BITS-1:0] r_error_count;

    logic [UART_COUNT-1:0]   w_sel;
    logic                    w_full_sel;
    logic                    w_chan_ok;
    logic                    w_hdr_ok;
    logic                    w_len_zero;
    logic                    w_last;
    logic                    w_pop;
    logic                    w_expire;
    logic                    w_error;

    // One-hot select of the registered channel; all-zero when the channel
    // is out of range, so an invalid channel can never stall or write.
    assign w_sel      = UART_COUNT'(1) << r_channel;
    assign w_full_sel = |(full & w_sel);
    assign w_chan_ok  = ({1'b0, r_channel} < c_UART_COUNT);
    assign w_hdr_ok   = (hdr_sync(fifo_data) == SYNC_NIBBLE);
    assign w_len_zero = (fifo_data == '0);
    assign w_last     = (r_remaining == DATA_BITS'(1));

    // Only the DATA state honours downstream backpressure.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            c_ST_DATA: w_pop = !fifo_empty && !w_full_sel;
            default:   w_pop = !fifo_empty;
        endcase
    end

    uart_frame_timeout #(
        .COUNTER_BITS   (COUNTER_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_pop || (r_state == c_ST_IDLE)),
        .o_expire (w_expire)
    );

    // The three error sources are mutually exclusive: the first two need a
    // pop, expiry needs its absence.
    assign w_error = ((r_state == c_ST_IDLE) && w_pop && !w_hdr_ok)
                   || ((r_state == c_ST_LEN) && w_pop && !w_len_zero && !w_chan_ok)
                   || w_expire;

    assign fifo_read   = w_pop;
    assign write       = ((r_state == c_ST_DATA) && w_pop) ? w_sel : '0;
    assign data        = fifo_data;
    assign frame_error = w_error;
    assign error_count = r_error_count;
    assign busy        = (r_state != c_ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_channel     <= '0;
            r_remaining   <= '0;
            r_error_count <= '0;
        end else begin
            if (w_error && (r_error_count != '1)) begin
                r_error_count <= r_error_count + 1'b1;
            end

            if (w_expire) begin
                r_state <= c_ST_IDLE;
            end else if (w_pop) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_hdr_ok) begin
                            r_channel <= hdr_chan(fifo_data);
                            r_state   <= c_ST_LEN;
                        end
                    end
                    c_ST_LEN: begin
                        r_remaining <= fifo_data;
                        if (w_len_zero) begin
                            r_state <= c_ST_IDLE;
                        end else if (w_chan_ok) begin
                            r_state <= c_ST_DATA;
                        end else begin
                            r_state <= c_ST_DROP;
                        end
                    end
                    default: begin
                        // DATA and DROP consume the payload identically;
                        // they differ only in whether write is driven.
                        r_remaining <= r_remaining - 1'b1;
                        if (w_last) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
